// File: rtl/vga_test_pattern.sv
// rtl/vga_test_pattern.sv - VGA test pattern generator with frame-synchronous pattern switching
module vga_test_pattern #(
  parameter int VIDEO_WIDTH = 3,
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   ihsync,
  input  logic                   ivsync,
  input  logic                   pattern_next,
  input  logic                   pattern_prev,
  output logic                   hsync,
  output logic                   vsync,
  output logic [VIDEO_WIDTH-1:0] oredv,
  output logic [VIDEO_WIDTH-1:0] ogrnv,
  output logic [VIDEO_WIDTH-1:0] obluv,
  output logic [2:0]             pattern
);

  localparam logic [9:0] LAST_COL  = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] LAST_ROW  = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] ACT_COLS  = 10'(ACTIVE_COLS);
  localparam logic [9:0] ACT_ROWS  = 10'(ACTIVE_ROWS);
  localparam logic [9:0] LAST_ACOL = 10'(ACTIVE_COLS - 1);
  localparam logic [9:0] LAST_AROW = 10'(ACTIVE_ROWS - 1);
  localparam logic [9:0] BAR_W     = 10'(ACTIVE_COLS / 8);
  localparam logic [VIDEO_WIDTH-1:0] ONES = {VIDEO_WIDTH{1'b1}};

  logic                   hs_q, vs_q;
  logic [9:0]             col_q, col_d, row_q, row_d;
  logic [2:0]             pat_pend_q, pat_pend_d, pat_cur_q, pat_cur_d;
  logic                   hsync_q, vsync_q;
  logic [VIDEO_WIDTH-1:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  logic                   frame_start;
  logic                   active;
  logic [9:0]             bar_idx;

  assign frame_start = ivsync && !vs_q;
  assign active      = (col_q < ACT_COLS) && (row_q < ACT_ROWS);
  assign bar_idx     = col_q / BAR_W;

  // col/row track the hs_q/vs_q pipeline stage, so they restart together with vs_q rising
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (frame_start) begin
      col_d = '0;
      row_d = '0;
    end else if (col_q == LAST_COL) begin
      col_d = '0;
      row_d = (row_q == LAST_ROW) ? 10'd0 : row_q + 10'd1;
    end else begin
      col_d = col_q + 10'd1;
    end
  end

  always_comb begin
    pat_pend_d = pat_pend_q;
    pat_cur_d  = pat_cur_q;
    case ({pattern_next, pattern_prev})
      2'b10:   pat_pend_d = pat_pend_q + 3'd1;
      2'b01:   pat_pend_d = pat_pend_q - 3'd1;
      default: pat_pend_d = pat_pend_q;
    endcase
    // the displayed index only changes at frame start and takes the pre-request value
    if (frame_start) pat_cur_d = pat_pend_q;
  end

  always_comb begin
    red_d = '0;
    grn_d = '0;
    blu_d = '0;
    if (active) begin
      case (pat_cur_q)
        3'd1: red_d = ONES;
        3'd2: grn_d = ONES;
        3'd3: blu_d = ONES;
        3'd4: begin
          if (col_q[5] ^ row_q[5]) begin
            red_d = ONES;
            grn_d = ONES;
            blu_d = ONES;
          end
        end
        3'd5: begin
          red_d = {VIDEO_WIDTH{bar_idx[2]}};
          grn_d = {VIDEO_WIDTH{bar_idx[1]}};
          blu_d = {VIDEO_WIDTH{bar_idx[0]}};
        end
        3'd6: begin
          if (col_q == 10'd0 || col_q == LAST_ACOL || row_q == 10'd0 || row_q == LAST_AROW) begin
            red_d = ONES;
            grn_d = ONES;
            blu_d = ONES;
          end
        end
        3'd7: begin
          red_d = col_q[9 -: VIDEO_WIDTH];
          grn_d = row_q[8 -: VIDEO_WIDTH];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      pat_pend_q <= '0;
      pat_cur_q  <= '0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      red_q      <= '0;
      grn_q      <= '0;
      blu_q      <= '0;
    end else begin
      hs_q       <= ihsync;
      vs_q       <= ivsync;
      col_q      <= col_d;
      row_q      <= row_d;
      pat_pend_q <= pat_pend_d;
      pat_cur_q  <= pat_cur_d;
      hsync_q    <= hs_q;
      vsync_q    <= vs_q;
      red_q      <= red_d;
      grn_q      <= grn_d;
      blu_q      <= blu_d;
    end
  end

  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign oredv   = red_q;
  assign ogrnv   = grn_q;
  assign obluv   = blu_q;
  assign pattern = pat_cur_q;

endmodule

// File: tb/tb_vga_test_pattern.sv
// tb/tb_vga_test_pattern.sv - scoreboard bench for vga_test_pattern on a reduced raster
module tb_vga_test_pattern;

  localparam int VW = 3;
  localparam int TC = 168;
  localparam int TR = 44;
  localparam int AC = 160;
  localparam int AR = 40;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          ihsync, ivsync, pattern_next, pattern_prev;
  logic          hsync, vsync;
  logic [VW-1:0] oredv, ogrnv, obluv;
  logic [2:0]    pattern;

  int n_vec = 0;
  int n_err = 0;

  logic [10:0] exp_q[$];
  logic [2:0]  pat_q[$];

  int   tc = 0, tr = 0, fr = 0;
  bit   m_prev_iv = 1'b0;
  logic [2:0] m_cur = 3'd0, m_pend = 3'd0;
  bit   did_rst = 1'b0;

  always #5 clock = ~clock;

  vga_test_pattern #(
    .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
    .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR)
  ) dut (
    .clock(clock), .reset_n(reset_n), .ihsync(ihsync), .ivsync(ivsync),
    .pattern_next(pattern_next), .pattern_prev(pattern_prev),
    .hsync(hsync), .vsync(vsync), .oredv(oredv), .ogrnv(ogrnv), .obluv(obluv),
    .pattern(pattern)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (frame %0d, t=%0t)", tag, obs, exp, fr, $time);
    end
  endtask

  function automatic logic [8:0] ref_rgb(input int c, input int r, input logic [2:0] p);
    logic [2:0] rr, gg, bb;
    int b;
    rr = 0; gg = 0; bb = 0;
    if (c < AC && r < AR) begin
      case (p)
        3'd1: rr = 3'd7;
        3'd2: gg = 3'd7;
        3'd3: bb = 3'd7;
        3'd4: if (((c / 32) + (r / 32)) % 2 == 1) {rr, gg, bb} = 9'h1ff;
        3'd5: begin
          b  = c / (AC / 8);
          rr = ((b >> 2) & 1) ? 3'd7 : 3'd0;
          gg = ((b >> 1) & 1) ? 3'd7 : 3'd0;
          bb = (b & 1) ? 3'd7 : 3'd0;
        end
        3'd6: if (c == 0 || c == AC - 1 || r == 0 || r == AR - 1) {rr, gg, bb} = 9'h1ff;
        3'd7: begin
          rr = 3'((c >> 7) & 7);
          gg = 3'((r >> 6) & 7);
        end
        default: ;
      endcase
    end
    return {rr, gg, bb};
  endfunction

  task automatic tick(input bit nx, input bit pv);
    bit fs;
    @(negedge clock);
    if (exp_q.size() == 2) check_eq("pixel", {hsync, vsync, oredv, ogrnv, obluv}, exp_q.pop_front());
    if (pat_q.size() == 1) check_eq("pattern", pattern, pat_q.pop_front());
    ihsync       = (tc < AC);
    ivsync       = (tr < AR);
    pattern_next = nx;
    pattern_prev = pv;
    if (reset_n) begin
      fs        = ivsync && !m_prev_iv;
      m_prev_iv = ivsync;
      if (fs) m_cur = m_pend;
      exp_q.push_back({ihsync, ivsync, ref_rgb(tc, tr, m_cur)});
      pat_q.push_back(m_cur);
      if (nx && !pv) m_pend = m_pend + 3'd1;
      else if (pv && !nx) m_pend = m_pend - 3'd1;
    end
    tc++;
    if (tc == TC) begin
      tc = 0;
      tr++;
      if (tr == TR) begin
        tr = 0;
        fr++;
      end
    end
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0);
    #2 reset_n = 1'b0;
    exp_q.delete();
    pat_q.delete();
    m_cur = 3'd0; m_pend = 3'd0; m_prev_iv = 1'b0;
    #1;
    check_eq("async_rst_pix", {hsync, vsync, oredv, ogrnv, obluv}, 32'd0);
    check_eq("async_rst_pat", pattern, 32'd0);
    repeat (3) tick(1'b1, 1'b0);
    @(posedge clock);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    bit nx, pv;
    reset_n = 1'b0; ihsync = 1'b0; ivsync = 1'b0;
    pattern_next = 1'b0; pattern_prev = 1'b0;
    #1;
    check_eq("reset_pix", {hsync, vsync, oredv, ogrnv, obluv}, 32'd0);
    check_eq("reset_pat", pattern, 32'd0);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;

    while (fr < 9) begin
      if (fr == 6 && tr == 20 && tc == 50 && !did_rst) begin
        do_reset();
        did_rst = 1'b1;
      end else begin
        nx = 1'b0; pv = 1'b0;
        if (tr == 5 && tc == 10) begin
          if (fr == 0) pv = 1'b1;
          else if (fr == 1 || fr == 2 || fr == 4 || fr == 5) nx = 1'b1;
        end
        if (tr == 6 && tc == 10) begin
          if (fr == 0) begin nx = 1'b1; pv = 1'b1; end
          else if (fr == 1) nx = 1'b1;
        end
        if (fr == 3 && tr == 0 && tc == 0) nx = 1'b1;
        if (fr == 6 && tr == 22 && (tc == 10 || tc == 11 || tc == 12)) nx = 1'b1;
        if (fr == 7 && tr == 5 && (tc == 10 || tc == 20 || tc == 30)) nx = 1'b1;
        tick(nx, pv);
      end
    end
    repeat (3) tick(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
